// File: rtl/i2c_target_tx_byte_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_tx_byte_pkg
// Description : Shared types and constants for the I2C target byte
//               transmitter: FSM state encoding, ACK/NACK bit values and
//               small helpers used by the transmit datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_target_tx_byte_pkg;

    // Transmit FSM state encoding (3-bit)
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ACK   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bus value of the acknowledge bit as driven by the controller
    localparam logic       c_I2C_ACK   = 1'b0;
    localparam logic       c_I2C_NACK  = 1'b1;

    // Shift register content that leaves SDA released for every bit
    localparam logic [7:0] c_SHIFT_REL = 8'hFF;

    // Bit index of the first (MSB) bit of a byte
    localparam logic [2:0] c_BIT_MSB   = 3'd7;

    // Smallest synchroniser depth that is safe against metastability
    localparam int         c_SYNC_MIN  = 2;

    // Open-drain mapping: a data 0 pulls SDA low, a data 1 releases it
    function automatic logic oe_for_bit(input logic b);
        return ~b;
    endfunction

    // True when the sampled acknowledge bit ends the read transfer
    function automatic logic is_nack(input logic b);
        return (b == c_I2C_NACK);
    endfunction

endpackage : i2c_target_tx_byte_pkg
`default_nettype wire

// File: rtl/i2c_target_tx_byte_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_tx_byte_if
// Description : Payload handshake between the byte source and the I2C target
//               transmitter.
//                 tx_data  - byte to transmit
//                 tx_valid - tx_data is valid
//                 tx_ready - asserted for the cycle in which tx_data is taken
//               modport master : payload source
//               modport slave  : transmitter
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_target_tx_byte_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface : i2c_target_tx_byte_if
`default_nettype wire

// File: rtl/i2c_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_edge_sync
// Description : Synchronises one raw I2C pin into the clk domain and derives
//               registered rise/fall strobes.
//                 clk     - system clock
//                 rst_n   - asynchronous active-low reset
//                 i_pin   - raw pin input
//                 o_level - synchronised pin level
//                 o_rise  - one-cycle strobe, SYNC_STAGES+1 cycles after a
//                           rising pin edge
//                 o_fall  - one-cycle strobe, SYNC_STAGES+1 cycles after a
//                           falling pin edge
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_edge_sync
    import i2c_target_tx_byte_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_pin,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall
);

    // Depths below the minimum are clamped rather than silently unsafe
    localparam int c_STAGES = (SYNC_STAGES < c_SYNC_MIN) ? c_SYNC_MIN : SYNC_STAGES;

    logic [c_STAGES-1:0] r_sync;
    logic                r_dly;
    logic                r_rise;
    logic                r_fall;

    // Flops reset to 1 so an idle (pulled-up) bus produces no spurious edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_dly  <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[c_STAGES-2:0], i_pin};
            r_dly  <= r_sync[c_STAGES-1];
            r_rise <=  r_sync[c_STAGES-1] & ~r_dly;
            r_fall <= ~r_sync[c_STAGES-1] &  r_dly;
        end
    end

    assign o_level = r_sync[c_STAGES-1];
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule : i2c_edge_sync
`default_nettype wire

// File: rtl/i2c_target_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_tx_byte
// Description : Target-side I2C byte transmitter for read transfers. Shifts
//               payload bytes MSB-first onto open-drain SDA and samples the
//               controller's ACK/NACK on the 9th SCL clock. Never drives SCL.
//                 clk         - system clock
//                 rst_n       - asynchronous active-low reset
//                 i_enable    - read phase active (from protocol FSM)
//                 i_stop_seen - one-cycle STOP / repeated START strobe
//                 i_scl       - raw SCL pin
//                 i_sda       - raw SDA pin
//                 bus         - payload handshake (tx_data/tx_valid/tx_ready)
//                 o_sda_oe    - 1 pulls SDA low, 0 releases it
//                 o_ack_valid - one-cycle strobe: ACK bit sampled
//                 o_ack_nack  - sampled ACK bit (1 = NACK), held
//                 o_busy      - FSM not idle
//                 o_underrun  - sticky: SCL rose before a byte was available
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_tx_byte
    import i2c_target_tx_byte_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            i_enable,
    input  wire logic            i_stop_seen,
    input  wire logic            i_scl,
    input  wire logic            i_sda,
    i2c_target_tx_byte_if.slave  bus,
    output logic                 o_sda_oe,
    output logic                 o_ack_valid,
    output logic                 o_ack_nack,
    output logic                 o_busy,
    output logic                 o_underrun
);

    // ------------------------------------------------------------------
    // Pin synchronisation and edge detection
    // ------------------------------------------------------------------
    logic w_scl_level;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda_s;
    logic w_sda_rise;
    logic w_sda_fall;

    i2c_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_scl_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (i_scl),
        .o_level (w_scl_level),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sda_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_pin   (i_sda),
        .o_level (w_sda_s),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    // ------------------------------------------------------------------
    // FSM, shift register and bit counter
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [7:0] r_shift_reg;
    logic [2:0] r_bit_cnt;
    logic       r_sda_oe;
    logic       r_ack_valid;
    logic       r_ack_nack;
    logic       r_busy;
    logic       r_underrun;

    logic       w_abort;
    logic       w_accept;
    logic [7:0] w_shift_next;

    // Any active state is abandoned on STOP/repeated START or when the
    // protocol FSM leaves the read phase; this wins over SCL edges.
    assign w_abort  = (r_state != ST_IDLE) && (i_stop_seen || !i_enable);

    // Payload is taken only while waiting for a byte and not aborting
    assign w_accept = (r_state == ST_LOAD) && bus.tx_valid && !w_abort;

    // Shift in ones so a released SDA follows the last data bit
    assign w_shift_next = {r_shift_reg[6:0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift_reg <= c_SHIFT_REL;
            r_bit_cnt   <= 3'd0;
            r_sda_oe    <= 1'b0;
            r_ack_valid <= 1'b0;
            r_ack_nack  <= c_I2C_ACK;
            r_busy      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_ack_valid <= 1'b0;

            if (w_abort) begin
                r_state    <= ST_IDLE;
                r_sda_oe   <= 1'b0;
                r_busy     <= 1'b0;
                r_underrun <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sda_oe <= 1'b0;
                        if (i_enable) begin
                            r_state <= ST_LOAD;
                            r_busy  <= 1'b1;
                        end
                    end

                    ST_LOAD: begin
                        // SCL is low on entry, so presenting bit 7 here
                        // never moves SDA while SCL is high.
                        if (bus.tx_valid) begin
                            r_shift_reg <= bus.tx_data;
                            r_bit_cnt   <= c_BIT_MSB;
                            r_sda_oe    <= oe_for_bit(bus.tx_data[7]);
                            r_state     <= ST_SHIFT;
                        end else if (w_scl_rise) begin
                            // Controller is already clocking bit 7: send an
                            // all-ones byte and flag the late payload.
                            r_underrun  <= 1'b1;
                            r_shift_reg <= c_SHIFT_REL;
                            r_bit_cnt   <= c_BIT_MSB;
                            r_sda_oe    <= 1'b0;
                            r_state     <= ST_SHIFT;
                        end
                    end

                    ST_SHIFT: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt != 3'd0) begin
                                r_shift_reg <= w_shift_next;
                                r_bit_cnt   <= r_bit_cnt - 3'd1;
                                r_sda_oe    <= oe_for_bit(w_shift_next[7]);
                            end else begin
                                // Release SDA for the controller's ACK bit
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_ACK;
                            end
                        end
                    end

                    ST_ACK: begin
                        if (w_scl_rise) begin
                            r_ack_nack  <= w_sda_s;
                            r_ack_valid <= 1'b1;
                        end else if (w_scl_fall) begin
                            r_state <= is_nack(r_ack_nack) ? ST_DONE : ST_LOAD;
                        end
                    end

                    ST_DONE: begin
                        // Exit happens through the abort path once the
                        // protocol FSM drops enable.
                        r_sda_oe <= 1'b0;
                    end

                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // SDA edges and the SCL level are not needed by the transmitter; the
    // shift register MSB mirrors the bit currently on the wire.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, w_sda_rise, w_sda_fall, w_scl_level, r_shift_reg[7]};

    assign bus.tx_ready = w_accept;
    assign o_sda_oe     = r_sda_oe;
    assign o_ack_valid  = r_ack_valid;
    assign o_ack_nack   = r_ack_nack;
    assign o_busy       = r_busy;
    assign o_underrun   = r_underrun;

endmodule : i2c_target_tx_byte
`default_nettype wire

// File: tb/tb_i2c_target_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_target_tx_byte
// Description : Scoreboard testbench for i2c_target_tx_byte. Stimulus queues
//               payload bytes and expected bus bytes / ACK values; monitors
//               compare the SDA line at each SCL rise and every ack_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target_tx_byte;
    import i2c_target_tx_byte_pkg::*;

    localparam int c_LOW  = 8;
    localparam int c_HIGH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       enable    = 1'b0;
    logic       stop_seen = 1'b0;
    logic       scl       = 1'b1;
    logic       ctrl_pull = 1'b0;
    logic [7:0] src_data  = 8'h00;
    logic       src_valid = 1'b0;
    logic       sda_line;

    logic oe, ack_valid, ack_nack, busy, underrun;
    logic oe3, ack_valid3, ack_nack3, busy3, underrun3;

    assign sda_line = ~(oe | ctrl_pull);

    i2c_target_tx_byte_if bus ();
    i2c_target_tx_byte_if bus3 ();

    assign bus.tx_data   = src_data;
    assign bus.tx_valid  = src_valid;
    assign bus3.tx_data  = 8'h55;
    assign bus3.tx_valid = 1'b1;

    i2c_target_tx_byte #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_stop_seen(stop_seen),
        .i_scl(scl), .i_sda(sda_line), .bus(bus),
        .o_sda_oe(oe), .o_ack_valid(ack_valid), .o_ack_nack(ack_nack),
        .o_busy(busy), .o_underrun(underrun)
    );

    i2c_target_tx_byte #(.SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_stop_seen(stop_seen),
        .i_scl(scl), .i_sda(sda_line), .bus(bus3),
        .o_sda_oe(oe3), .o_ack_valid(ack_valid3), .o_ack_nack(ack_nack3),
        .o_busy(busy3), .o_underrun(underrun3)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] src_q[$];
    logic [7:0] exp_bytes[$];
    logic       exp_acks[$];
    logic       mon_en = 1'b0;
    int         ready_pulses = 0;
    int         oe_changes = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Payload source: sample tx_ready mid-cycle, update valid just after the edge
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (bus.tx_ready === 1'b1) begin
                if (src_q.size() > 0) void'(src_q.pop_front());
                run++;
            end else begin
                if (run > 0) begin
                    chk("tx_ready_width", run, 1);
                    ready_pulses++;
                end
                run = 0;
            end
            @(posedge clk);
            #1;
            src_valid = (src_q.size() > 0);
            src_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    // Bus byte monitor: SDA line sampled on every SCL rise, 9 bits per frame
    initial begin
        int         mcnt;
        logic [7:0] acc;
        logic [7:0] e;
        mcnt = 0;
        acc  = 8'h00;
        forever begin
            @(posedge scl);
            if (!mon_en) begin
                mcnt = 0;
            end else begin
                if (mcnt < 8) acc = {acc[6:0], sda_line};
                mcnt++;
                if (mcnt == 8) begin
                    if (exp_bytes.size() == 0) begin
                        chk("bus_byte_unexpected", {24'h0, acc}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_bytes.pop_front();
                        chk("bus_byte", {24'h0, acc}, {24'h0, e});
                    end
                end else if (mcnt == 9) begin
                    mcnt = 0;
                end
            end
        end
    end

    // ACK monitor
    initial begin
        logic e;
        forever begin
            @(posedge clk);
            #1;
            if (ack_valid === 1'b1) begin
                if (exp_acks.size() == 0) begin
                    chk("ack_unexpected", {31'h0, ack_nack}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_acks.pop_front();
                    chk("ack_nack", {31'h0, ack_nack}, {31'h0, e});
                end
            end
        end
    end

    // SDA may only move while SCL is low
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (oe !== prev) begin
                chk("oe_change_scl_low", {31'h0, scl}, 32'h0);
                oe_changes++;
                prev = oe;
            end
        end
    end

    task automatic pulse(input logic pull);
        @(negedge clk);
        ctrl_pull = pull;
        repeat (c_LOW) @(negedge clk);
        scl = 1'b1;
        repeat (c_HIGH) @(negedge clk);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic ack_pull);
        repeat (8) pulse(1'b0);
        pulse(ack_pull);
        @(negedge clk);
        ctrl_pull = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int   p0, lag2, lag3, c0;
        logic prev2, prev3;

        // ---------------- reset state ----------------
        wait_cycles(3);
        #1;
        chk("rst_sda_oe", {31'h0, oe}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_ack", {30'h0, ack_valid, ack_nack}, 0);
        chk("rst_underrun", {31'h0, underrun}, 0);
        chk("rst_tx_ready", {31'h0, bus.tx_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(3);
        scl = 1'b0;
        wait_cycles(10);

        // ---------------- A5 ACK, 3C NACK, sync lag ----------------
        mon_en = 1'b1;
        p0 = ready_pulses;
        src_q.push_back(8'hA5); src_q.push_back(8'h3C);
        exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h3C);
        exp_acks.push_back(1'b0); exp_acks.push_back(1'b1);
        enable = 1'b1;
        wait_cycles(6);
        chk("a5_bit7_oe", {31'h0, oe}, 0);
        ctrl_pull = 1'b0;
        repeat (c_LOW) @(negedge clk);
        scl = 1'b1;
        repeat (c_HIGH) @(negedge clk);
        prev2 = oe;
        prev3 = oe3;
        scl = 1'b0;
        lag2 = 0;
        lag3 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (lag2 == 0 && oe !== prev2) lag2 = k;
            if (lag3 == 0 && oe3 !== prev3) lag3 = k;
        end
        chk("lag_sync2", lag2, 4);
        chk("lag_sync3", lag3, 5);
        repeat (7) pulse(1'b0);
        pulse(1'b1);
        @(negedge clk);
        ctrl_pull = 1'b0;
        send_byte(1'b0);
        wait_cycles(4);
        chk("s1_state_done", {29'h0, dut.r_state}, {29'h0, ST_DONE});
        chk("s1_busy", {31'h0, busy}, 1);
        chk("s1_oe_released", {31'h0, oe}, 0);
        chk("s1_ready_pulses", ready_pulses - p0, 2);
        chk("s1_acks_drained", exp_acks.size(), 0);
        enable = 1'b0;
        wait_cycles(3);
        chk("s1_idle_busy", {31'h0, busy}, 0);

        // ---------------- back-to-back 3C, C3 ----------------
        p0 = ready_pulses;
        src_q.push_back(8'h3C); src_q.push_back(8'hC3);
        exp_bytes.push_back(8'h3C); exp_bytes.push_back(8'hC3);
        exp_acks.push_back(1'b0); exp_acks.push_back(1'b0);
        enable = 1'b1;
        wait_cycles(6);
        send_byte(1'b1);
        send_byte(1'b1);
        wait_cycles(4);
        chk("s2_ready_pulses", ready_pulses - p0, 2);
        chk("s2_state_load", {29'h0, dut.r_state}, {29'h0, ST_LOAD});
        chk("s2_bytes_drained", exp_bytes.size(), 0);
        enable = 1'b0;
        wait_cycles(3);
        chk("s2_idle_busy", {31'h0, busy}, 0);

        // ---------------- underrun ----------------
        exp_bytes.push_back(8'hFF);
        exp_acks.push_back(1'b1);
        enable = 1'b1;
        wait_cycles(6);
        chk("s3_underrun_before", {31'h0, underrun}, 0);
        chk("s3_busy", {31'h0, busy}, 1);
        pulse(1'b0);
        chk("s3_underrun_set", {31'h0, underrun}, 1);
        repeat (7) pulse(1'b0);
        pulse(1'b0);
        wait_cycles(4);
        chk("s3_state_done", {29'h0, dut.r_state}, {29'h0, ST_DONE});
        chk("s3_underrun_held", {31'h0, underrun}, 1);
        enable = 1'b0;
        wait_cycles(3);
        chk("s3_underrun_cleared", {31'h0, underrun}, 0);
        mon_en = 1'b0;

        // ---------------- stop_seen abort ----------------
        src_q.push_back(8'h00);
        enable = 1'b1;
        wait_cycles(6);
        repeat (4) pulse(1'b0);
        wait_cycles(6);
        chk("s4_oe_before_stop", {31'h0, oe}, 1);
        @(negedge clk);
        stop_seen = 1'b1;
        @(posedge clk);
        #1;
        chk("s4_oe_after_stop", {31'h0, oe}, 0);
        chk("s4_busy_after_stop", {31'h0, busy}, 0);
        @(negedge clk);
        stop_seen = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        c0 = oe_changes;
        repeat (9) pulse(1'b0);
        wait_cycles(6);
        chk("s4_no_oe_activity", oe_changes - c0, 0);
        chk("s4_still_idle", {31'h0, busy}, 0);

        // ---------------- asynchronous reset mid-byte ----------------
        src_q.push_back(8'h00);
        enable = 1'b1;
        wait_cycles(6);
        repeat (2) pulse(1'b0);
        wait_cycles(6);
        chk("s5_oe_bit5", {31'h0, oe}, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("s5_rst_oe", {31'h0, oe}, 0);
        chk("s5_rst_outputs", {28'h0, busy, underrun, ack_valid, ack_nack}, 0);
        chk("s5_rst_state", {29'h0, dut.r_state}, {29'h0, ST_IDLE});
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(10);
        enable = 1'b1;
        @(posedge clk);
        #1;
        chk("s5_restart_load", {29'h0, dut.r_state}, {29'h0, ST_LOAD});
        @(posedge clk);
        #1;
        chk("s5_restart_busy", {31'h0, busy}, 1);
        @(negedge clk);
        enable = 1'b0;
        wait_cycles(5);

        chk("final_bytes_empty", exp_bytes.size(), 0);
        chk("final_acks_empty", exp_acks.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_i2c_target_tx_byte
`default_nettype wire

// File: doc/i2c_target_tx_byte.md
Name: i2c_target_tx_byte

Overview:
- Target-side I2C byte transmitter for read transfers: serialises bytes MSB-first onto open-drain SDA and samples the controller's ACK/NACK on the 9th clock.
- Complements the existing receive path; the protocol FSM asserts `enable` once the read phase begins, i.e. after the address ACK falling edge while SCL is low.
- The payload source feeds bytes through a valid/ready handshake.
- The block never drives SCL.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i before edge detection (minimum 2).

Ports:
- clk  in  1  system clock, posedge
- rst_n  in  1  asynchronous reset, active-low
- enable  in  1  read phase active (from protocol FSM)
- stop_seen  in  1  single-cycle strobe: STOP or repeated START detected
- scl_i  in  1  raw SCL pin input
- sda_i  in  1  raw SDA pin input
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  one-cycle pulse: tx_data accepted
- sda_oe  out  1  1 = pull SDA low; 0 = release
- ack_valid  out  1  one-cycle pulse: ACK bit sampled
- ack_nack  out  1  sampled ACK value (1 = NACK); holds until next ack_valid
- busy  out  1  state != IDLE
- underrun  out  1  sticky: SCL rose before a byte was available; cleared on entry to IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; sda_oe, tx_ready, ack_valid, ack_nack, busy and underrun all 0; shift_reg=8'hFF; bit_cnt=0.
- Edge detect:
  - scl_i/sda_i pass through SYNC_STAGES flops, then one delay flop.
  - scl_rise/scl_fall are one-cycle strobes SYNC_STAGES+1 cycles after the pin edge.
  - sda_s is the synchronised SDA.
- sda_oe is registered: it changes 1 cycle after the causing strobe/event.
- States:
  - IDLE: sda_oe=0. enable=1 -> LOAD.
  - LOAD:
    - tx_valid=1 -> tx_ready pulse, shift_reg<=tx_data, bit_cnt<=7, sda_oe<=~tx_data[7] -> SHIFT.
    - scl_rise while tx_valid=0 -> underrun<=1, shift_reg<=8'hFF, sda_oe<=0, bit_cnt<=7 -> SHIFT. The released bit is transmitted as 1; this cycle counts as bit 7.
  - SHIFT, on scl_fall:
    - bit_cnt!=0 -> shift left (fill 1), bit_cnt--, sda_oe<=~new shift_reg[7].
    - bit_cnt==0 -> sda_oe<=0 -> ACK.
  - ACK:
    - scl_rise -> ack_nack<=sda_s, ack_valid pulse.
    - Next scl_fall: ACK (0) -> LOAD, next byte; NACK (1) -> DONE.
  - DONE: sda_oe=0; enable=0 -> IDLE.
- Abort: stop_seen=1 or enable=0 in any non-IDLE state -> IDLE next cycle, sda_oe<=0. Abort has priority over all edges in the same cycle.
- tx_ready is only ever asserted in LOAD.
  - tx_valid and scl_rise in the same LOAD cycle: data accepted, no underrun.
- Simultaneous scl_rise and scl_fall strobes cannot occur (single edge-detect flop).
- SDA never changes while SCL is high: updates happen only on scl_fall or LOAD acceptance. The protocol FSM guarantees LOAD is entered while SCL is low.
- Mid-operation reset: immediate release (sda_oe=0 asynchronously); bit/byte state discarded.

Decomposition:
- Shared include i2c_defs.vh: state encodings (IDLE, LOAD, SHIFT, ACK, DONE, 3-bit), I2C_ACK=1'b0, I2C_NACK=1'b1.
- Sub-module i2c_edge_sync:
  - Parameter SYNC_STAGES; clk/rst_n.
  - Synchronises one pin; outputs level, rise, fall.
  - Instantiated for SCL and SDA.
  - Synchroniser flops reset to 1 (bus idle high).
- FSM, shift register and bit counter live in the top module.

Test Plan:
- enable, tx_data=8'hA5 valid, 9 SCL pulses, controller ACK then NACK on second byte 8'h3C:
  - sda_oe sequence per bit = 0,1,0,1,1,0,1,0 for A5;
  - ack_valid twice, ack_nack=0 then 1;
  - state DONE; tx_ready pulsed exactly twice.
- Back-to-back bytes 8'h3C, 8'hC3, both ACKed:
  - bus samples 3C then C3;
  - each tx_ready one cycle wide;
  - sda_oe only changes 1 cycle after an scl_fall strobe or acceptance.
- tx_valid held low until after first scl_rise:
  - underrun=1; bus samples 8'hFF;
  - underrun clears only on return to IDLE.
- stop_seen pulse after 4th bit of 8'h00 (sda_oe=1):
  - sda_oe=0 next cycle, busy=0;
  - subsequent SCL edges produce no output.
- rst_n asserted mid-byte (bit 5 of 8'h00):
  - sda_oe=0 without a clk edge; all outputs at reset values;
  - after release, next enable restarts at LOAD.
- SYNC_STAGES=3:
  - sda_oe change lags SCL pin falling edge by exactly 5 clk cycles: 3 sync + 1 delay + 1 register.
